// File: rtl/fb_pkg.sv
// Shared constants for the frame-buffer write path.
package fb_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int PIXEL_W = 5;
  localparam int ADDR_W  = 19;
  localparam int COORD_W = 10;

  localparam logic [PIXEL_W-1:0] TRANSPARENT = 5'h16;

  // Scheduler states: IDLE samples requests, WRITE presents the latched write.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] WRITE = 1'b1;

endpackage

// File: rtl/fb_addr_gen.sv
// Scrolled screen coordinate to frame RAM address, plus an in-range flag.
// Purely combinational so the read-side scroll logic can reuse it.
module fb_addr_gen
  import fb_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] scroll,
  output logic [ADDR_W-1:0]  address,
  output logic               inRange
);

  logic [COORD_W:0]  xSum;
  logic [COORD_W:0]  xWrap;
  logic [ADDR_W-1:0] rowBase;

  // Add the scroll offset, wrap once at the line width, then form y*H_RES + x.
  // A single subtraction suffices for every in-range x; out-of-range
  // addresses are never written so their value does not matter.
  always_comb begin
    xSum    = {1'b0, x} + {1'b0, scroll};
    xWrap   = (xSum >= (COORD_W+1)'(H_RES)) ? xSum - (COORD_W+1)'(H_RES) : xSum;
    rowBase = ADDR_W'(y) * ADDR_W'(H_RES);
    address = rowBase + ADDR_W'(xWrap);
    inRange = (x < COORD_W'(H_RES)) && (y < COORD_W'(V_RES));
  end

endmodule

// File: rtl/frame_write_scheduler.sv
// Two-requester write arbiter for the frame RAM. Writes are granted only
// during blanking; each accepted request occupies one IDLE and one WRITE cycle.
module frame_write_scheduler
  import fb_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               blank,
  input  logic               frame_tick,
  input  logic               ScrollEnable,
  input  logic               req0,
  input  logic               req1,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [PIXEL_W-1:0] pix0,
  input  logic [PIXEL_W-1:0] pix1,
  output logic               grant0,
  output logic               grant1,
  output logic               we,
  output logic [ADDR_W-1:0]  write_address,
  output logic [PIXEL_W-1:0] data_out,
  output logic [COORD_W-1:0] scroll_x,
  output logic               err_oob,
  output logic [15:0]        write_count
);

  logic [0:0]         state;
  logic               rr;
  logic               sel;
  logic               pickSel;
  logic [COORD_W-1:0] xLat;
  logic [COORD_W-1:0] yLat;
  logic [PIXEL_W-1:0] pixLat;
  logic [COORD_W-1:0] scrollLat;
  logic [COORD_W-1:0] scrollReg;
  logic [15:0]        countReg;
  logic [ADDR_W-1:0]  genAddress;
  logic               genInRange;
  logic               inWrite;

  fb_addr_gen u_addr_gen (
    .x       (xLat),
    .y       (yLat),
    .scroll  (scrollLat),
    .address (genAddress),
    .inRange (genInRange)
  );

  // Requester choice: a lone request wins outright, a tie goes to rr.
  always_comb begin
    pickSel = req1 && (!req0 || rr);
  end

  // Arbitration FSM; payload and scroll offset are captured in IDLE so the
  // requester may move on as soon as it sees its grant.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      rr        <= 1'b0;
      sel       <= 1'b0;
      xLat      <= '0;
      yLat      <= '0;
      pixLat    <= '0;
      scrollLat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (blank && (req0 || req1)) begin
            sel       <= pickSel;
            xLat      <= pickSel ? x1 : x0;
            yLat      <= pickSel ? y1 : y0;
            pixLat    <= pickSel ? pix1 : pix0;
            scrollLat <= scrollReg;
            state     <= WRITE;
          end
        end
        default: begin
          rr    <= ~sel;
          state <= IDLE;
        end
      endcase
    end
  end

  // Horizontal scroll advances once per frame and wraps at the line width.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      scrollReg <= '0;
    end else if (frame_tick && ScrollEnable) begin
      if (scrollReg == COORD_W'(H_RES - 1)) begin
        scrollReg <= '0;
      end else begin
        scrollReg <= scrollReg + 1'b1;
      end
    end
  end

  // Per-frame committed-write counter; a write coinciding with the frame
  // tick is the first write of the new frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      countReg <= '0;
    end else if (frame_tick) begin
      countReg <= we ? 16'd1 : 16'd0;
    end else if (we && (countReg != 16'hFFFF)) begin
      countReg <= countReg + 16'd1;
    end
  end

  // WRITE-cycle outputs come straight from the latched request.
  always_comb begin
    inWrite       = (state == WRITE);
    grant0        = inWrite && !sel;
    grant1        = inWrite && sel;
    we            = inWrite && genInRange && (pixLat != TRANSPARENT);
    err_oob       = inWrite && !genInRange;
    write_address = inWrite ? genAddress : '0;
    data_out      = inWrite ? pixLat : '0;
    scroll_x      = scrollReg;
    write_count   = countReg;
  end

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Scoreboard bench for frame_write_scheduler: stimulus pushes expected
// writes, a negedge monitor pops and compares on every grant.
module tb_frame_write_scheduler;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        blank;
  logic        frame_tick;
  logic        ScrollEnable;
  logic        req0, req1;
  logic [9:0]  x0, y0, x1, y1;
  logic [4:0]  pix0, pix1;
  logic        grant0, grant1, we, err_oob;
  logic [18:0] write_address;
  logic [4:0]  data_out;
  logic [9:0]  scroll_x;
  logic [15:0] write_count;

  typedef struct {
    logic        sel;
    logic        we;
    logic [18:0] addr;
    logic [4:0]  data;
    logic        oob;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  frame_write_scheduler dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .blank         (blank),
    .frame_tick    (frame_tick),
    .ScrollEnable  (ScrollEnable),
    .req0          (req0),
    .req1          (req1),
    .x0            (x0),
    .y0            (y0),
    .x1            (x1),
    .y1            (y1),
    .pix0          (pix0),
    .pix1          (pix1),
    .grant0        (grant0),
    .grant1        (grant1),
    .we            (we),
    .write_address (write_address),
    .data_out      (data_out),
    .scroll_x      (scroll_x),
    .err_oob       (err_oob),
    .write_count   (write_count)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: every grant must match the head of the scoreboard.
  always @(negedge Clk) begin
    if (!Reset) begin
      if (grant0 || grant1) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("grant_sel", {30'b0, grant1, grant0}, e.sel ? 2 : 1);
          chk("we", {31'b0, we}, {31'b0, e.we});
          chk("err_oob", {31'b0, err_oob}, {31'b0, e.oob});
          if (e.we) begin
            chk("write_address", {13'b0, write_address}, {13'b0, e.addr});
            chk("data_out", {27'b0, data_out}, {27'b0, e.data});
          end
          if (e.cyc >= 0) chk("grant_cycle", cyc, e.cyc);
          $display("write: sel=%0d we=%0d addr=%0d data=%0h oob=%0d cycle=%0d",
                   grant1, we, write_address, data_out, err_oob, cyc);
        end
      end else begin
        chk("stray_we_oob", {31'b0, we | err_oob}, 0);
      end
    end
  end

  // Called just after a posedge; request appears this cycle, grant expected next.
  task automatic writeOne(input bit sel, input int x, input int y, input int pix,
                          input bit expWe, input int expAddr, input bit expOob);
    exp_t e;
    int   n;
    e.sel  = sel;
    e.we   = expWe;
    e.addr = 19'(expAddr);
    e.data = 5'(pix);
    e.oob  = expOob;
    e.cyc  = cyc + 1;
    sb.push_back(e);
    if (sel) begin
      req1 = 1'b1; x1 = 10'(x); y1 = 10'(y); pix1 = 5'(pix);
    end else begin
      req0 = 1'b1; x0 = 10'(x); y0 = 10'(y); pix0 = 5'(pix);
    end
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (!(sel ? grant1 : grant0) && n < 20);
    if (n >= 20) begin
      chk("grant_wait", 0, 1);
      sb.delete();
    end
    @(posedge Clk); #1;
    if (sel) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge Clk);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
    @(posedge Clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; blank = 1'b1; frame_tick = 1'b0; ScrollEnable = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0; pix0 = '0; pix1 = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    chk("rst_grants", {30'b0, grant1, grant0}, 0);
    chk("rst_we", {31'b0, we}, 0);
    chk("rst_addr", {13'b0, write_address}, 0);
    chk("rst_data", {27'b0, data_out}, 0);
    chk("rst_scroll", {22'b0, scroll_x}, 0);
    chk("rst_count", {16'b0, write_count}, 0);
    @(posedge Clk); #1;

    // Single write, scroll 0: 2*640+3 = 1283.
    writeOne(0, 3, 2, 5'h04, 1, 1283, 0);
    chk("count_single", {16'b0, write_count}, 1);

    // Transparent code: granted, not written, count unchanged.
    writeOne(0, 10, 1, 5'h16, 0, 650, 0);
    chk("count_transp", {16'b0, write_count}, 1);

    // Blank low: held off for 10 cycles, then granted the cycle after blank rises.
    blank = 1'b0; req1 = 1'b1; x1 = 10'd7; y1 = 10'd3; pix1 = 5'h09;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("blank_hold", {30'b0, grant1, grant0}, 0);
    end
    @(posedge Clk); #1;
    blank = 1'b1;
    writeOne(1, 7, 3, 5'h09, 1, 1927, 0);
    chk("count_blank", {16'b0, write_count}, 2);

    // Contention with rr=0: grants 0,1,0,1 every second cycle.
    begin
      exp_t e;
      int c0;
      c0 = cyc;
      req0 = 1'b1; x0 = 10'd1; y0 = 10'd0; pix0 = 5'h01;
      req1 = 1'b1; x1 = 10'd2; y1 = 10'd0; pix1 = 5'h02;
      for (int k = 0; k < 4; k++) begin
        e.sel  = k[0];
        e.we   = 1'b1;
        e.addr = k[0] ? 19'd2 : 19'd1;
        e.data = k[0] ? 5'h02 : 5'h01;
        e.oob  = 1'b0;
        e.cyc  = c0 + 1 + 2 * k;
        sb.push_back(e);
      end
      repeat (8) @(posedge Clk);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      waitDrain();
    end
    chk("count_contention", {16'b0, write_count}, 6);

    // Out-of-range coordinates: granted, no write, error pulse.
    writeOne(0, 640, 0, 5'h03, 0, 0, 1);
    writeOne(0, 0, 480, 5'h03, 0, 0, 1);
    chk("count_oob", {16'b0, write_count}, 6);

    // 639 frame ticks with scrolling enabled.
    ScrollEnable = 1'b1; frame_tick = 1'b1;
    repeat (639) @(posedge Clk);
    #1 frame_tick = 1'b0;
    @(negedge Clk);
    chk("scroll_639", {22'b0, scroll_x}, 639);
    chk("count_cleared", {16'b0, write_count}, 0);
    @(posedge Clk); #1;

    // 5 + 639 = 644 wraps to 4.
    writeOne(0, 5, 0, 5'h02, 1, 4, 0);
    chk("count_wrapwr", {16'b0, write_count}, 1);

    // 640th tick brings the scroll back to 0.
    frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0;
    @(negedge Clk);
    chk("scroll_wrap0", {22'b0, scroll_x}, 0);
    @(posedge Clk); #1;

    // Tick in the latch cycle: old offset 0 is used (640+5 = 645).
    frame_tick = 1'b1;
    fork
      writeOne(0, 5, 1, 5'h07, 1, 645, 0);
      begin @(posedge Clk); #1 frame_tick = 1'b0; end
    join
    chk("scroll_after_latch", {22'b0, scroll_x}, 1);
    chk("count_latch_tick", {16'b0, write_count}, 1);

    // Tick in the write cycle: counter loads 1 instead of reaching 2.
    fork
      writeOne(0, 0, 0, 5'h01, 1, 1, 0);
      begin
        @(posedge Clk); #1 frame_tick = 1'b1;
        @(posedge Clk); #1 frame_tick = 1'b0;
      end
    join
    chk("count_we_tick", {16'b0, write_count}, 1);
    chk("scroll_2", {22'b0, scroll_x}, 2);

    // Scroll holds with ScrollEnable low.
    ScrollEnable = 1'b0; frame_tick = 1'b1;
    @(posedge Clk); #1 frame_tick = 1'b0;
    @(negedge Clk);
    chk("scroll_hold", {22'b0, scroll_x}, 2);
    chk("count_tick_only", {16'b0, write_count}, 0);
    @(posedge Clk); #1;

    // Reset during the latch cycle: the write is dropped.
    Reset = 1'b1; req0 = 1'b1; x0 = 10'd4; y0 = 10'd4; pix0 = 5'h05;
    @(posedge Clk); #1;
    Reset = 1'b0; req0 = 1'b0;
    @(negedge Clk);
    chk("mid_rst_grants", {30'b0, grant1, grant0}, 0);
    chk("mid_rst_we", {31'b0, we}, 0);
    chk("mid_rst_oob", {31'b0, err_oob}, 0);
    chk("mid_rst_addr", {13'b0, write_address}, 0);
    chk("mid_rst_scroll", {22'b0, scroll_x}, 0);
    chk("mid_rst_count", {16'b0, write_count}, 0);
    repeat (5) @(posedge Clk);
    #1;
    chk("mid_rst_no_write", {16'b0, write_count}, 0);
    chk("sb_final", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_write_scheduler.md
Name: frame_write_scheduler

Overview:
- Arbitrates pixel-write requests from two requesters (background tile engine, sprite engine) onto the single frame RAM write port.
- Grants writes only while the display is blanked, so scan-out reads are never disturbed.
- Owns the horizontal scroll offset, applies it to each write address, and suppresses writes of the transparency code.
- Sits between the rendering engines and the frame buffer, driving its write-enable, write address and write data.

Parameters:
- H_RES, 640, visible pixels per line; also the scroll wrap modulus.
- V_RES, 480, visible lines.
- PIXEL_W, 5, encoded pixel width.
- ADDR_W, 19, frame RAM address width.
- TRANSPARENT, 5'h16, pixel code that is never written.

Ports:
- Clk  in  1  system clock; the only clock.
- Reset  in  1  synchronous, active-high reset.
- blank  in  1  high during blanking; writes are granted only while high.
- frame_tick  in  1  one-Clk pulse at frame start (vsync edge, already synchronised to Clk).
- ScrollEnable  in  1  when high, scroll_x advances on each frame_tick.
- req0, req1  in  1 each  write requests; held, with payload stable, until the matching grant.
- x0, y0, x1, y1  in  10 each  target screen coordinates per requester.
- pix0, pix1  in  PIXEL_W each  pixel code per requester.
- grant0, grant1  out  1 each  one-cycle acknowledge; the payload was consumed.
- we  out  1  frame RAM write enable.
- write_address  out  ADDR_W  frame RAM write address.
- data_out  out  PIXEL_W  frame RAM write data.
- scroll_x  out  10  current scroll offset.
- err_oob  out  1  one-cycle pulse when a granted request had x>=H_RES or y>=V_RES.
- write_count  out  16  committed writes in the current frame.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer rr=0.
- State IDLE (cycle N):
  - If blank and (req0 or req1), select a requester. Only one pending: pick it. Both pending: rr=0 picks req0, rr=1 picks req1.
  - Latch the chosen x, y, pix and the current scroll_x. Go to WRITE.
  - Otherwise stay in IDLE.
- State WRITE (cycle N+1):
  - Assert grant of the selected requester for exactly this cycle.
  - Drive write_address and data_out from the latched values.
  - we=1 only if coordinates are in range and pix != TRANSPARENT.
  - Out-of-range coordinates: grant still issued, we=0, err_oob=1.
  - rr becomes the non-selected index. Next state is always IDLE.
- Throughput: at most one write per 2 cycles. Latency from request sampled to we is 1 cycle.
- Requester rule: req may drop, or present the next payload, in the cycle after grant. The scheduler does not re-sample in WRITE, so no double-grant is possible.
- Address arithmetic:
  - xe = x + scroll_l, computed 11 bits wide.
  - If xe >= H_RES, xe = xe - H_RES.
  - write_address = y*H_RES + xe, truncated to ADDR_W.
  - Maximum address 307199 fits in 19 bits.
- Blank falls while in WRITE: the write completes; no new grant until blank returns.
- req asserted while blank is low: held off with no grant and no error.
- Scroll:
  - On frame_tick with ScrollEnable=1: scroll_x+1, wrapping 639→0.
  - ScrollEnable=0: scroll_x holds.
  - frame_tick in the same cycle as an IDLE latch: the latch uses the old scroll_x.
- write_count:
  - Increments on each cycle with we=1; saturates at 16'hFFFF.
  - frame_tick clears it to 0. If we=1 in the same cycle, it loads 1.
- Reset mid-operation: next cycle we=0, grants 0, scroll_x=0; the pending write is dropped and never issued.

Decomposition:
- Package fb_pkg holds H_RES, V_RES, PIXEL_W, ADDR_W, TRANSPARENT, and the state enum {IDLE, WRITE}.
- One combinational sub-module, fb_addr_gen (x, y, scroll → address plus in-range flag), shared later by read-side scroll logic.

Test Plan:
- Single request: blank=1, scroll 0, req0 with x=3, y=2, pix=5'h04 → grant0 and we at N+1; address 1283, data 5'h04; write_count=1.
- Transparent pixel: pix0=5'h16 → grant0=1, we=0; write_count unchanged.
- Contention: req0 and req1 held 4 writes, rr=0 → grants alternate 0,1,0,1 on cycles N+1, N+3, N+5, N+7.
- Scroll wrap:
  - 640 frame_ticks with ScrollEnable=1 → scroll_x returns to 0.
  - At scroll_x=639, write x=5, y=0 → address 4.
  - Tick coincident with a latch → old offset used.
- Blank gating and out-of-range:
  - req1 with blank=0 for 10 cycles → no grant.
  - Raise blank → grant1 at the second cycle.
  - x=640 → grant, we=0, err_oob pulse.
- Reset mid-write: assert Reset during the IDLE latch cycle → no grant and no we afterwards; all outputs 0; write_count=0.
